// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage PC sequencing bundle: bus handshake, redirect pulses, PC mux feedback and status.
interface fetch_pc_ctrl_if;
  logic        ahb_ready_in;
  logic        trap_taken_in;
  logic        mret_in;
  logic        mis_instr_in;
  logic [31:0] pc_mux_in;
  logic [1:0]  pc_src_out;
  logic [30:0] pc_out;
  logic        fetch_valid_out;
  logic        flush_out;
  logic        misaligned_trap_out;
  logic        pending_out;
  logic        bus_timeout_out;

  modport master (
    output ahb_ready_in, trap_taken_in, mret_in, mis_instr_in, pc_mux_in,
    input  pc_src_out, pc_out, fetch_valid_out, flush_out,
           misaligned_trap_out, pending_out, bus_timeout_out
  );

  modport slave (
    input  ahb_ready_in, trap_taken_in, mret_in, mis_instr_in, pc_mux_in,
    output pc_src_out, pc_out, fetch_valid_out, flush_out,
           misaligned_trap_out, pending_out, bus_timeout_out
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// PC register and source-select sequencer; redirects serviced the cycle the bus is ready, status one cycle later.
// A low ahb_ready_in holds PC and select while new trap/mret pulses are latched until serviced.
module fetch_pc_ctrl #(
  parameter logic [31:0] BOOT_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  fetch_pc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_RST, ST_BOOT, ST_RUN} state_t;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state;
  logic [30:0] pc;
  logic        trap_pend;
  logic        mret_pend;
  logic        fetch_valid;
  logic        flush;
  logic        mis_trap;
  logic        timeout;
  logic [7:0]  tmo_cnt;
  logic        trap_e;
  logic        mret_e;
  logic [1:0]  src;
  logic        mux_lsb_unused;

  // The halfword-granular PC drops bit 0; odd targets are reported via mis_instr_in.
  assign mux_lsb_unused = bus.pc_mux_in[0];

  always_comb begin
    trap_e = bus.trap_taken_in | trap_pend;
    mret_e = bus.mret_in | mret_pend;
    src    = 2'b00;
    if (state == ST_RUN) begin
      if (trap_e)      src = 2'b10;
      else if (mret_e) src = 2'b01;
      else             src = 2'b11;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_RST;
      pc          <= BOOT_ADDR[31:1];
      trap_pend   <= 1'b0;
      mret_pend   <= 1'b0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      mis_trap    <= 1'b0;
      timeout     <= 1'b0;
      tmo_cnt     <= 8'd0;
    end else begin
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      mis_trap    <= 1'b0;
      case (state)
        ST_RST: state <= ST_BOOT;
        ST_BOOT: begin
          trap_pend <= trap_pend | bus.trap_taken_in;
          mret_pend <= mret_pend | bus.mret_in;
          if (bus.ahb_ready_in) begin
            pc          <= bus.pc_mux_in[31:1];
            fetch_valid <= 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.ahb_ready_in) begin
            trap_pend <= trap_e;
            mret_pend <= mret_e;
          end else begin
            unique case (src)
              2'b10: begin
                // A trap swallows any pending or simultaneous mret.
                pc          <= bus.pc_mux_in[31:1];
                fetch_valid <= 1'b1;
                flush       <= 1'b1;
                trap_pend   <= 1'b0;
                mret_pend   <= 1'b0;
              end
              2'b01: begin
                pc          <= bus.pc_mux_in[31:1];
                fetch_valid <= 1'b1;
                flush       <= 1'b1;
                mret_pend   <= 1'b0;
              end
              default: begin
                if (bus.mis_instr_in) begin
                  mis_trap <= 1'b1;
                end else begin
                  pc          <= bus.pc_mux_in[31:1];
                  fetch_valid <= 1'b1;
                end
              end
            endcase
          end
        end
        default: state <= ST_RST;
      endcase
      if (state != ST_RST) begin
        if (bus.ahb_ready_in) begin
          tmo_cnt <= 8'd0;
        end else if (tmo_cnt < TMO_LIM) begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_cnt == TMO_LIM - 8'd1) timeout <= 1'b1;
        end
      end
    end
  end

  assign bus.pc_src_out          = src;
  assign bus.pc_out              = pc;
  assign bus.fetch_valid_out     = fetch_valid;
  assign bus.flush_out           = flush;
  assign bus.misaligned_trap_out = mis_trap;
  assign bus.pending_out         = trap_pend | mret_pend;
  assign bus.bus_timeout_out     = timeout;
endmodule
